// File: rtl/uart_fifo_buffer_pkg.sv
// Widths and reset constants shared by the UART receiver, this FIFO and
// uart_alu_interface.
package uart_fifo_buffer_pkg;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_RX_FIFO_ADDR_W = 4;
    localparam int UART_TX_FIFO_ADDR_W = 2;

    localparam int   FIFO_PTR_RST_VAL  = 0;
    localparam logic FIFO_EMPTY_RST    = 1'b1;
    localparam logic FIFO_FULL_RST     = 1'b0;
    localparam logic FIFO_ERR_FLAG_RST = 1'b0;

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE  = 2'b00,
        FIFO_OP_READ  = 2'b01,
        FIFO_OP_WRITE = 2'b10,
        FIFO_OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic wr_en, input logic rd_en);
        return fifo_op_e'({wr_en, rd_en});
    endfunction

endpackage

// File: rtl/uart_fifo_buffer_fifo_ctrl.sv
// Pointer, occupancy and flag control for uart_fifo_buffer.
// Optional sticky error flags under `UART_FIFO_ERR_FLAGS_EN.
module uart_fifo_buffer_fifo_ctrl
    import uart_fifo_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = UART_RX_FIFO_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic                  i_rd,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ADDR_WIDTH-1:0] o_r_addr,
    output logic                  o_empty,
    output logic                  o_full,
`ifdef UART_FIFO_ERR_FLAGS_EN
    output logic                  o_overflow,
    output logic                  o_underflow,
`endif
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1'b1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] PTR_RST = ADDR_WIDTH'(FIFO_PTR_RST_VAL);

    logic [ADDR_WIDTH-1:0] w_ptr_r;
    logic [ADDR_WIDTH-1:0] r_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  empty_r;
    logic                  full_r;

    logic                  wr_en_s;
    logic                  rd_en_s;
    fifo_op_e              op_s;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] r_ptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  empty_nxt_s;
    logic                  full_nxt_s;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign wr_en_s = i_wr & (~full_r | i_rd);
    assign rd_en_s = i_rd & ~empty_r;
    assign op_s    = fifo_op(wr_en_s, rd_en_s);

    // Next-state pointers, occupancy and flags.
    always_comb begin
        w_ptr_nxt_s = w_ptr_r;
        r_ptr_nxt_s = r_ptr_r;
        count_nxt_s = count_r;
        empty_nxt_s = empty_r;
        full_nxt_s  = full_r;
        case (op_s)
            FIFO_OP_WRITE: begin
                w_ptr_nxt_s = w_ptr_r + PTR_ONE;
                count_nxt_s = count_r + CNT_ONE;
                empty_nxt_s = 1'b0;
                full_nxt_s  = (w_ptr_nxt_s == r_ptr_r);
            end
            FIFO_OP_READ: begin
                r_ptr_nxt_s = r_ptr_r + PTR_ONE;
                count_nxt_s = count_r - CNT_ONE;
                full_nxt_s  = 1'b0;
                empty_nxt_s = (r_ptr_nxt_s == w_ptr_r);
            end
            FIFO_OP_BOTH: begin
                w_ptr_nxt_s = w_ptr_r + PTR_ONE;
                r_ptr_nxt_s = r_ptr_r + PTR_ONE;
            end
            FIFO_OP_IDLE: begin
                w_ptr_nxt_s = w_ptr_r;
            end
            default: begin
                w_ptr_nxt_s = w_ptr_r;
            end
        endcase
    end

    // State registers; reset wins over any concurrent request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            w_ptr_r <= PTR_RST;
            r_ptr_r <= PTR_RST;
            count_r <= CNT_W'(FIFO_PTR_RST_VAL);
            empty_r <= FIFO_EMPTY_RST;
            full_r  <= FIFO_FULL_RST;
        end else begin
            w_ptr_r <= w_ptr_nxt_s;
            r_ptr_r <= r_ptr_nxt_s;
            count_r <= count_nxt_s;
            empty_r <= empty_nxt_s;
            full_r  <= full_nxt_s;
        end
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags recording dropped writes and ignored reads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overflow_r  <= FIFO_ERR_FLAG_RST;
            underflow_r <= FIFO_ERR_FLAG_RST;
        end else begin
            overflow_r  <= overflow_r  | (i_wr & full_r & ~i_rd);
            underflow_r <= underflow_r | (i_rd & empty_r & ~i_wr);
        end
    end

    assign o_overflow  = overflow_r;
    assign o_underflow = underflow_r;
`endif

    assign o_wr_en  = wr_en_s;
    assign o_w_addr = w_ptr_r;
    assign o_r_addr = r_ptr_r;
    assign o_empty  = empty_r;
    assign o_full   = full_r;
    assign o_count  = count_r;

endmodule

// File: rtl/uart_fifo_buffer.sv
// First-word-fall-through byte FIFO between the UART and the ALU interface.
// Define UART_FIFO_ERR_FLAGS_EN to add sticky o_overflow/o_underflow outputs.
module uart_fifo_buffer
    import uart_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = UART_RX_FIFO_ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_empty,
    output logic                  o_full,
`ifdef UART_FIFO_ERR_FLAGS_EN
    output logic                  o_overflow,
    output logic                  o_underflow,
`endif
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] w_addr_s;
    logic [ADDR_WIDTH-1:0] r_addr_s;

    uart_fifo_buffer_fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo_ctrl (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr        (i_wr),
        .i_rd        (i_rd),
        .o_wr_en     (wr_en_s),
        .o_w_addr    (w_addr_s),
        .o_r_addr    (r_addr_s),
        .o_empty     (o_empty),
        .o_full      (o_full),
`ifdef UART_FIFO_ERR_FLAGS_EN
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
`endif
        .o_count     (o_count)
    );

    // Storage array; deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[w_addr_s] <= i_w_data;
        end
    end

    // Head word falls through combinationally so a reader sees it without a pop.
    assign o_r_data = mem_r[r_addr_s];

endmodule

// File: tb/tb_uart_fifo_buffer.sv
// Directed self-checking bench for uart_fifo_buffer at depth 4.
module tb_uart_fifo_buffer;

    logic       clk;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
`ifdef UART_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int checks   = 0;
    int failures = 0;

    uart_fifo_buffer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_wr        (wr),
        .i_w_data    (w_data),
        .i_rd        (rd),
        .o_r_data    (r_data),
        .o_empty     (empty),
        .o_full      (full),
`ifdef UART_FIFO_ERR_FLAGS_EN
        .o_overflow  (overflow),
        .o_underflow (underflow),
`endif
        .o_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; w_data = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: empty=%b full=%b count=%0d, expected 1 0 0", empty, full, count);
        end
        rd = 1'b1;
        repeat (3) tick();
        rd = 1'b0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL read_empty: empty=%b full=%b count=%0d, expected 1 0 0", empty, full, count);
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set: underflow=%b, expected 1", underflow);
        end
`endif
    endtask

    task automatic test_single();
        do_reset();
        push(8'hA1);
        checks++;
        if (empty !== 1'b0 || r_data !== 8'hA1 || count !== 3'd1) begin
            failures++;
            $display("FAIL single_write: empty=%b data=%h count=%0d, expected 0 a1 1", empty, r_data, count);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            failures++;
            $display("FAIL single_read: empty=%b count=%0d, expected 1 0", empty, count);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_v = 8'(i + 1);
            push(exp_v);
        end
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
            failures++;
            $display("FAIL fill: full=%b count=%0d empty=%b, expected 1 4 0", full, count, empty);
        end
        push(8'h05);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || r_data !== 8'h01) begin
            failures++;
            $display("FAIL overflow_drop: full=%b count=%0d head=%h, expected 1 4 01", full, count, r_data);
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_flag: ovf=%b unf=%b, expected 1 0", overflow, underflow);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            exp_v = 8'(i + 1);
            checks++;
            if (r_data !== exp_v) begin
                failures++;
                $display("FAIL drain_data[%0d]: got %h, expected %h", i, r_data, exp_v);
            end
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        checks++;
        if (empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL drained: empty=%b count=%0d full=%b, expected 1 0 0", empty, count, full);
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: ovf=%b, expected 1", overflow);
        end
`endif
    endtask

    task automatic test_full_both();
        logic [7:0] exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_v = 8'(i + 1);
            push(exp_v);
        end
        wr = 1'b1; rd = 1'b1; w_data = 8'h55;
        tick();
        wr = 1'b0; rd = 1'b0;
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || r_data !== 8'h02) begin
            failures++;
            $display("FAIL full_both: full=%b count=%0d head=%h, expected 1 4 02", full, count, r_data);
        end
        for (int i = 0; i < 3; i++) begin
            exp_v = 8'(i + 2);
            checks++;
            if (r_data !== exp_v) begin
                failures++;
                $display("FAIL full_both_drain[%0d]: got %h, expected %h", i, r_data, exp_v);
            end
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        checks++;
        if (r_data !== 8'h55 || count !== 3'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL full_both_tail: head=%h count=%0d empty=%b, expected 55 1 0", r_data, count, empty);
        end
    endtask

    task automatic test_empty_both();
        do_reset();
        wr = 1'b1; rd = 1'b1; w_data = 8'h3C;
        tick();
        wr = 1'b0; rd = 1'b0;
        checks++;
        if (count !== 3'd1 || r_data !== 8'h3C || empty !== 1'b0) begin
            failures++;
            $display("FAIL empty_both: count=%0d head=%h empty=%b, expected 1 3c 0", count, r_data, empty);
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL empty_both_unf: unf=%b, expected 0", underflow);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(8'h10);
        push(8'h11);
        push(8'h12);
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_count: count=%0d, expected 3", count);
        end
        reset = 1'b1; wr = 1'b1; w_data = 8'h99;
        tick();
        reset = 1'b0; wr = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: empty=%b count=%0d full=%b, expected 1 0 0", empty, count, full);
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: ovf=%b unf=%b, expected 0 0", overflow, underflow);
        end
`endif
        push(8'h77);
        checks++;
        if (r_data !== 8'h77 || count !== 3'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_write: head=%h count=%0d empty=%b, expected 77 1 0", r_data, count, empty);
        end
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        tick();
        test_reset();
        test_single();
        test_fill_drain();
        test_full_both();
        test_empty_both();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
